alu_scheduler: RTL

- Shares one 64-bit combinational ALU (5-bit op_code, result + carry_out) between two requesters.
- Round-robin arbitration; one operation in flight at a time.
- Holds operands stable on the ALU inputs for a programmable settle time, then captures result/carry into a response register with valid/ready backpressure.
- Traps divide/modulus by zero and undefined op codes before they reach the response, flagging them as errors.

---
 rtl/alu_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_scheduler.sv
// Round-robin scheduler that shares one external 64-bit ALU between two requesters.
// Each operation is held on the ALU for EXEC_CYCLES, then returned through a valid/ready response register.
module alu_scheduler #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic [4:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   input  logic [4:0]  req1_op,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [4:0]  alu_op,
   input  logic [63:0] alu_result,
   input  logic        alu_carry,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_carry,
   output logic        rsp_id,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [4:0] OP_DIV  = 5'b01100;
   localparam logic [4:0] OP_MOD  = 5'b01101;
   localparam logic [4:0] OP_LAST = 5'b10011;
   localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

   state_t      state;
   logic [3:0]  counter;
   logic        last_grant;

   logic        grant1;
   logic        accept;
   logic        acc_trap;
   logic [63:0] acc_a;
   logic [63:0] acc_b;
   logic [4:0]  acc_op;

   // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
   always_comb begin
      grant1     = req1_valid & (~req0_valid | ~last_grant);
      req1_ready = (state == IDLE) & grant1;
      req0_ready = (state == IDLE) & req0_valid & ~grant1;
      accept     = req0_ready | req1_ready;
      acc_a      = grant1 ? req1_a  : req0_a;
      acc_b      = grant1 ? req1_b  : req0_b;
      acc_op     = grant1 ? req1_op : req0_op;
      acc_trap   = (acc_op > OP_LAST) ||
                   (((acc_op == OP_DIV) || (acc_op == OP_MOD)) && (acc_b == 64'd0));
   end

   // NOTE: reset is sampled on the clock edge, and only control and output registers exist here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         counter    <= 4'd0;
         last_grant <= 1'b1;
         alu_a      <= 64'd0;
         alu_b      <= 64'd0;
         alu_op     <= 5'd0;
         rsp_valid  <= 1'b0;
         rsp_result <= 64'd0;
         rsp_carry  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a      <= acc_a;
                  alu_b      <= acc_b;
                  alu_op     <= acc_op;
                  rsp_id     <= grant1;
                  last_grant <= grant1;
                  counter    <= 4'd0;
                  if (acc_trap) begin
                     rsp_result <= 64'd0;
                     rsp_carry  <= 1'b0;
                     rsp_err    <= 1'b1;
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end else begin
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               counter <= counter + 4'd1;
               if (counter == LAST_CNT) begin
                  rsp_result <= alu_result;
                  rsp_carry  <= alu_carry;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               // The handshake edge returns to IDLE; a new request can only be taken one edge later.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
